// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   XLEN            - datapath width
//   INSTR_NOP       - instruction presented on out_instr after reset
//   FETCH_BUF_DEPTH - entries in the fetch output buffer
//   fetch_entry_t   - one buffered {pc, instr} pair
//   fetch_state_t   - boot/run sequencing of the fetch stage
//   align_pc()      - forces a byte address onto a word boundary
package fetch_pkg;

  localparam int unsigned XLEN            = 32;
  localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;
  localparam int unsigned FETCH_BUF_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // ST_BOOT is the single cycle after reset release; issuing starts in ST_RUN.
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the instruction-memory port, the redirect inputs
// and the {pc, instr} output handshake of instr_fetch.
//   master modport - the fetch stage
//   slave  modport - the memory/core side
// When FETCH_PERF_EN is defined the bundle also carries the two
// performance counters perf_fetch_cnt / perf_stall_cnt.
interface instr_fetch_if #(
  parameter int unsigned IMEM_AW = 9
);
  import fetch_pkg::*;

  logic               imem_rd_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_rdata;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_instr;
  logic [XLEN-1:0]    out_pc;
  logic               misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0]        perf_fetch_cnt;
  logic [31:0]        perf_stall_cnt;

  modport master (
    output imem_rd_en, imem_addr, out_valid, out_instr, out_pc, misalign_err,
    output perf_fetch_cnt, perf_stall_cnt,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_rd_en, imem_addr, out_valid, out_instr, out_pc, misalign_err,
    input  perf_fetch_cnt, perf_stall_cnt,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
`else
  modport master (
    output imem_rd_en, imem_addr, out_valid, out_instr, out_pc, misalign_err,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_rd_en, imem_addr, out_valid, out_instr, out_pc, misalign_err,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
`endif

endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry FIFO of fetch_entry_t feeding the core.
// The head entry is held in its own register so the output pair comes
// straight from flops and never moves while it is not being popped.
//   push/push_data - write one entry (caller guarantees space)
//   pop            - remove the head entry (caller guarantees non-empty)
//   flush          - empty the FIFO; wins over push and pop
//   count          - number of valid entries (0..2)
//   head           - oldest entry; holds reset/stale contents when empty
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  localparam logic [1:0] FULL_CNT = 2'(FETCH_BUF_DEPTH);

  fetch_entry_t ent0_r, ent1_r;
  fetch_entry_t ent0_nxt_s, ent1_nxt_s;
  logic [1:0]   count_r, count_nxt_s;

  // Next-state of the two entries and the occupancy count.
  always_comb begin
    ent0_nxt_s  = ent0_r;
    ent1_nxt_s  = ent1_r;
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) begin
            ent0_nxt_s = push_data;
          end else begin
            ent1_nxt_s = push_data;
          end
          count_nxt_s = count_r + 2'd1;
        end
        2'b01: begin
          ent0_nxt_s  = ent1_r;
          count_nxt_s = count_r - 2'd1;
        end
        2'b11: begin
          // With one entry the new word becomes the head directly.
          if (count_r == FULL_CNT) begin
            ent0_nxt_s = ent1_r;
            ent1_nxt_s = push_data;
          end else begin
            ent0_nxt_s = push_data;
          end
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end
  end

  // Entry and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_r  <= '{pc: RESET_PC, instr: INSTR_NOP};
      ent1_r  <= '{pc: RESET_PC, instr: INSTR_NOP};
      count_r <= 2'd0;
    end else begin
      ent0_r  <= ent0_nxt_s;
      ent1_r  <= ent1_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;
  assign head  = ent0_r;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage in front of the decode/execute core.
// Owns the PC, drives a 1-cycle-latency synchronous instruction memory and
// hands {pc, instr} pairs to the core over a valid/ready handshake.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - instr_fetch_if.master: imem_rd_en/imem_addr/imem_rdata,
//                redirect_valid/redirect_pc, out_valid/out_ready/out_pc/
//                out_instr, misalign_err
// Optional: define FETCH_PERF_EN to add perf_fetch_cnt (accepted transfers)
// and perf_stall_cnt (cycles with out_valid && !out_ready) to the bundle.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     IMEM_AW  = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  fetch_state_t    state_r, state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] resp_pc_r;   // pc of the read currently in flight
  logic            inflight_r;
  logic            misalign_r;

  logic [1:0]      count_s;
  fetch_entry_t    head_s;
  fetch_entry_t    push_entry_s;
  logic            out_valid_s;
  logic            deq_s;
  logic            push_s;
  logic            issue_s;
  logic [2:0]      occ_s;

  // Handshake and buffer-occupancy terms; a redirect hides the buffer at once.
  always_comb begin
    out_valid_s  = (count_s != 2'd0) && !bus.redirect_valid;
    deq_s        = out_valid_s && bus.out_ready;
    // A response landing in a redirect cycle belongs to the wrong path.
    push_s       = inflight_r && !bus.redirect_valid;
    push_entry_s = '{pc: resp_pc_r, instr: bus.imem_rdata};
    // Slots already committed after this cycle's dequeue; never underflows
    // because deq_s needs count_s >= 1.
    occ_s        = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, deq_s};
  end

  // Boot/run sequencing and the issue decision.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
        issue_s     = 1'b0;
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
        issue_s     = (occ_s < 3'd2) && !bus.redirect_valid;
      end
      default: begin
        state_nxt_s = ST_BOOT;
        issue_s     = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // PC, in-flight tracking and the registered misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      inflight_r <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      misalign_r <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect_valid) begin
        fetch_pc_r <= align_pc(bus.redirect_pc);
      end else if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
        resp_pc_r  <= fetch_pc_r;
      end
    end
  end

  fetch_skid_buf #(
    .RESET_PC (RESET_PC)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (deq_s),
    .flush     (bus.redirect_valid),
    .count     (count_s),
    .head      (head_s)
  );

  assign bus.imem_rd_en   = issue_s;
  assign bus.imem_addr    = fetch_pc_r[IMEM_AW+1:2];
  assign bus.out_valid    = out_valid_s;
  assign bus.out_pc       = head_s.pc;
  assign bus.out_instr    = head_s.instr;
  assign bus.misalign_err = misalign_r;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_r;
  logic [31:0] perf_stall_r;

  // Free-running event counters; redirects do not clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_r <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (deq_s) begin
        perf_fetch_r <= perf_fetch_r + 32'd1;
      end
      if (out_valid_s && !bus.out_ready) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign bus.perf_fetch_cnt = perf_fetch_r;
  assign bus.perf_stall_cnt = perf_stall_r;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: a cycle table drives out_ready/redirect and
// lists hand-derived outputs, followed by hand-written sequences for the
// full-buffer redirect, mid-stream reset and PC wrap-around.
module tb_instr_fetch;

  localparam logic [31:0] W0  = 32'h0226_8193;
  localparam logic [31:0] W1  = 32'h0010_0093;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] mem [0:511];

  instr_fetch_if #(.IMEM_AW(9)) bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (9)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read instruction memory, one cycle of latency.
  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        erd;
    logic        emis;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    logic [8:0] idx;
    idx = pc[10:2];
    if (idx == 9'd0) return W0;
    if (idx == 9'd1) return W1;
    return 32'hA500_0000 | {23'd0, idx};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic ev, input logic [31:0] epc,
                           input logic erd, input logic emis);
    chk({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, ev});
    chk({tag, " imem_rd_en"}, {31'd0, bus.imem_rd_en}, {31'd0, erd});
    chk({tag, " misalign_err"}, {31'd0, bus.misalign_err}, {31'd0, emis});
    if (ev) begin
      chk({tag, " out_pc"}, bus.out_pc, epc);
      chk({tag, " out_instr"}, bus.out_instr, exp_instr(epc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc, input logic ev,
                     input logic [31:0] epc, input logic erd, input logic emis);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc; v.erd = erd; v.emis = emis;
    vt.push_back(v);
  endtask

  // Asserts reset, checks the reset image, then releases it just after an edge.
  task automatic apply_reset(input string tag);
    drive(1'b1, 1'b0, 32'd0);
    rst_n = 1'b0;
    #3;
    chk({tag, " rst out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " rst imem_rd_en"}, {31'd0, bus.imem_rd_en}, 32'd0);
    chk({tag, " rst misalign"}, {31'd0, bus.misalign_err}, 32'd0);
    chk({tag, " rst out_pc"}, bus.out_pc, 32'd0);
    chk({tag, " rst out_instr"}, bus.out_instr, NOP);
    tick();
    chk({tag, " rst held rd_en"}, {31'd0, bus.imem_rd_en}, 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = W0;
    mem[1] = W1;

    // rdy rv rpc | valid pc rd_en misalign   (row index = cycle after release)
    add(1, 0, 32'h0,  0, 32'h0,  1, 0);  // 0 first issue
    add(1, 0, 32'h0,  0, 32'h0,  1, 0);  // 1
    add(1, 0, 32'h0,  1, 32'h0,  1, 0);  // 2 first output
    add(1, 0, 32'h0,  1, 32'h4,  1, 0);  // 3
    add(1, 0, 32'h0,  1, 32'h8,  1, 0);  // 4
    add(0, 0, 32'h0,  1, 32'hC,  0, 0);  // 5 stall: buffer fills
    add(0, 0, 32'h0,  1, 32'hC,  0, 0);  // 6
    add(0, 0, 32'h0,  1, 32'hC,  0, 0);  // 7
    add(0, 0, 32'h0,  1, 32'hC,  0, 0);  // 8
    add(0, 0, 32'h0,  1, 32'hC,  0, 0);  // 9
    add(1, 0, 32'h0,  1, 32'hC,  1, 0);  // 10 release
    add(1, 0, 32'h0,  1, 32'h10, 1, 0);  // 11
    add(1, 0, 32'h0,  1, 32'h14, 1, 0);  // 12
    add(1, 0, 32'h0,  1, 32'h18, 1, 0);  // 13
    add(1, 1, 32'h40, 0, 32'h0,  0, 0);  // 14 redirect R
    add(1, 0, 32'h0,  0, 32'h0,  1, 0);  // 15 target issued
    add(1, 0, 32'h0,  0, 32'h0,  1, 0);  // 16
    add(1, 0, 32'h0,  1, 32'h40, 1, 0);  // 17 R+3
    add(1, 0, 32'h0,  1, 32'h44, 1, 0);  // 18
    add(1, 1, 32'h42, 0, 32'h0,  0, 0);  // 19 misaligned redirect
    add(1, 0, 32'h0,  0, 32'h0,  1, 1);  // 20 misalign pulse
    add(1, 0, 32'h0,  0, 32'h0,  1, 0);  // 21
    add(1, 0, 32'h0,  1, 32'h40, 1, 0);  // 22
    add(1, 0, 32'h0,  1, 32'h44, 1, 0);  // 23

    tick();
    apply_reset("init");
    foreach (vt[i]) begin
      tick();
      drive(vt[i].rdy, vt[i].rv, vt[i].rpc);
      #3;
      chk_cycle($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].erd, vt[i].emis);
    end

    // Fill the buffer with out_ready low, then redirect while full.
    tick(); drive(1'b0, 1'b0, 32'd0); #3; chk_cycle("full s1", 1'b1, 32'h48, 1'b0, 1'b0);
    tick(); #3;                           chk_cycle("full s2", 1'b1, 32'h48, 1'b0, 1'b0);
    tick(); #3;                           chk_cycle("full s3", 1'b1, 32'h48, 1'b0, 1'b0);
    tick(); drive(1'b0, 1'b1, 32'h80); #3; chk_cycle("flush R", 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); drive(1'b1, 1'b0, 32'd0); #3; chk_cycle("flush R+1", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush R+1 imem_addr", {23'd0, bus.imem_addr}, 32'h20);
    tick(); #3;                           chk_cycle("flush R+2", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush R+2 imem_addr", {23'd0, bus.imem_addr}, 32'h21);
    tick(); #3;                           chk_cycle("flush R+3", 1'b1, 32'h80, 1'b1, 1'b0);
    tick(); #3;                           chk_cycle("flush R+4", 1'b1, 32'h84, 1'b1, 1'b0);

    // Reset in the middle of a stream, then restart from RESET_PC.
    tick();
    apply_reset("mid");
    tick(); #3; chk_cycle("restart c0", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("restart c0 imem_addr", {23'd0, bus.imem_addr}, 32'h0);
    tick(); #3; chk_cycle("restart c1", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); #3; chk_cycle("restart c2", 1'b1, 32'h0, 1'b1, 1'b0);
    tick(); #3; chk_cycle("restart c3", 1'b1, 32'h4, 1'b1, 1'b0);

    // Redirect to the last word of the address space and wrap to zero.
    tick(); drive(1'b1, 1'b1, 32'hFFFF_FFFC); #3; chk_cycle("wrap R", 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); drive(1'b1, 1'b0, 32'd0); #3; chk_cycle("wrap R+1", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap R+1 imem_addr", {23'd0, bus.imem_addr}, 32'h1FF);
    tick(); #3; chk_cycle("wrap R+2", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap R+2 imem_addr", {23'd0, bus.imem_addr}, 32'h0);
    tick(); #3; chk_cycle("wrap R+3", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    tick(); #3; chk_cycle("wrap R+4", 1'b1, 32'h0, 1'b1, 1'b0);
    tick(); #3; chk_cycle("wrap R+5", 1'b1, 32'h4, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage, directly upstream of the cpu decode/execute core.
- Owns the PC and drives a synchronous-read instruction memory with 1-cycle read latency.
- Delivers {pc, instr} pairs to the core over a valid/ready handshake.
- Accepts branch/jump redirects from the core and discards wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- IMEM_AW, 9, instruction-memory word-address width.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_rd_en  out  1  read strobe to instruction memory.
- imem_addr  out  IMEM_AW  word address, fetch_pc[IMEM_AW+1:2].
- imem_rdata  in  32  read data, valid the cycle after imem_rd_en.
- redirect_valid  in  1  core requests PC change.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  {out_pc, out_instr} valid.
- out_ready  in  1  core accepts this cycle.
- out_instr  out  32  instruction word.
- out_pc  out  32  byte address of out_instr.
- misalign_err  out  1  one-cycle registered pulse when a redirect target has pc[1:0] != 0.

Behaviour:
- Reset (async assert, sync to clk on release):
  - out_valid=0, out_instr=32'h0000_0013 (NOP), out_pc=RESET_PC.
  - imem_rd_en=0, misalign_err=0.
  - fetch_pc=RESET_PC, buffer empty.
  - Any in-flight read is discarded. Asserting reset mid-stream clears everything immediately.
- Buffer and handshake:
  - 2-entry output FIFO of {pc, instr}.
  - out_valid = FIFO non-empty AND NOT redirect_valid.
  - Transfer occurs when out_valid && out_ready.
  - out_pc and out_instr stay stable while out_valid && !out_ready.
- Issue rule:
  - imem_rd_en=1 when (count + inflight − deq) < 2 AND NOT redirect_valid.
  - inflight is a 1-bit flag for a read issued last cycle. deq is the transfer this cycle.
  - On issue, fetch_pc <= fetch_pc + 4 (mod 2^32; 0xFFFF_FFFC wraps to 0). imem_addr aliases above 2^IMEM_AW words.
  - Response is written to the FIFO at the end of the cycle after issue.
- Latency and throughput:
  - Issue at cycle N gives out_valid at N+2. The first issue is the first cycle after rst_n release.
  - Sustained 1 instruction/cycle when out_ready=1.
- Redirect in cycle R:
  - FIFO cleared at the edge ending R. The response arriving in R is dropped.
  - No issue in R.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Target issued in R+1, out_valid in R+3.
  - Redirect overrides simultaneous full FIFO / out_ready=0.
- Misalign: misalign_err=1 in R+1 only. Fetch proceeds from the aligned target.
- No FSM beyond states RUN and the implicit post-reset first-issue cycle. All behaviour follows from count, inflight and fetch_pc.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt counts accepted transfers.
  - perf_stall_cnt counts cycles with out_valid && !out_ready.
  - Both reset to 0, wrap at 2^32, and clear on redirect? No: they are not cleared by redirect.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - XLEN=32, INSTR_NOP=32'h0000_0013, FETCH_BUF_DEPTH=2.
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
- Sub-module fetch_skid_buf: the 2-entry FIFO of fetch_entry_t with push, pop, flush, count and head.

Test Plan:
1. Preload word0=0x02268193, word1=0x00100093; release reset with out_ready=1 → out_valid at cycle 2: pc=0, instr=0x02268193. Cycle 3: pc=4, instr=0x00100093. Then one per cycle.
2. Stream, then out_ready=0 for 5 cycles → outputs stable and imem_rd_en low once 2 entries are buffered. On release, pcs continue consecutively with no loss or duplicate.
3. redirect_valid with redirect_pc=0x40 during stream → out_valid=0 in R; next accepted pc=0x40 at R+3; no wrong-path pc accepted.
4. redirect_pc=0x42 → misalign_err high for exactly R+1; next accepted pc=0x40.
5. FIFO full, out_ready=0, redirect to 0x80 → flush wins; next pc=0x80. Then assert rst_n=0 mid-stream → out_valid=0 immediately; restart at RESET_PC.
6. Redirect to 0xFFFF_FFFC → pcs 0xFFFF_FFFC, then 0x0000_0000; imem_addr wraps accordingly.
